// File: rtl/picorv32_ahb_master.sv
// PicoRV32 native port -> AHB-Lite SINGLE transfers, one at a time; mem_ready 3 cycles after mem_valid (+2 per extra beat),
// stretched by HREADY wait states. Define AHB_MST_ERR_IRQ_EN to add the sticky err_irq/err_addr/err_clr error capture.
module picorv32_ahb_master #(
  parameter bit HPROT_PRIV = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
`ifdef AHB_MST_ERR_IRQ_EN
  output logic        err_irq,
  output logic [31:0] err_addr,
  input  logic        err_clr,
`endif
  input  logic        HRESP
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [2:0] SZ_BYTE   = 3'b000;
  localparam logic [2:0] SZ_HALF   = 3'b001;
  localparam logic [2:0] SZ_WORD   = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  typedef struct packed {
    logic [1:0] off;
    logic [2:0] size;
    logic [3:0] rest;
  } beat_t;

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    logic [1:0] l;
    casez (m)
      4'b???1: l = 2'd0;
      4'b??10: l = 2'd1;
      4'b?100: l = 2'd2;
      default: l = 2'd3;
    endcase
    return l;
  endfunction

  // Aligned patterns go out as one beat; anything else becomes byte beats, lowest lane first.
  function automatic beat_t first_beat(input logic [3:0] strb);
    beat_t b;
    b.off  = 2'd0;
    b.size = SZ_WORD;
    b.rest = 4'b0000;
    case (strb)
      4'b0000, 4'b1111: b.size = SZ_WORD;
      4'b0011: b.size = SZ_HALF;
      4'b1100: begin
        b.size = SZ_HALF;
        b.off  = 2'd2;
      end
      default: begin
        b.size = SZ_BYTE;
        b.off  = low_lane(strb);
        b.rest = strb & ~(4'b0001 << b.off);
      end
    endcase
    return b;
  endfunction

  state_t      state, state_nxt;
  logic [29:0] base, base_nxt;
  logic [31:0] wdata_l, wdata_nxt;
  logic [3:0]  rest, rest_nxt;
  logic [1:0]  htrans_nxt;
  logic [31:0] haddr_nxt, hwdata_nxt, rdata_nxt;
  logic        hwrite_nxt, ready_nxt;
  logic [2:0]  hsize_nxt;
  logic [3:0]  hprot_nxt;
  logic [1:0]  next_lane;
  beat_t       first;
  logic        unused;

  assign unused    = &{1'b0, mem_addr[1:0]};
  assign first     = first_beat(mem_wstrb);
  assign next_lane = low_lane(rest);
  assign HBURST    = 3'b000;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (mem_valid) state_nxt = S_ADDR;
      S_ADDR: if (HREADY) state_nxt = S_DATA;
      S_DATA: if (HREADY) state_nxt = (HRESP || rest == 4'b0000) ? S_RESP : S_ADDR;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    htrans_nxt = TR_IDLE;
    haddr_nxt  = HADDR;
    hwrite_nxt = HWRITE;
    hsize_nxt  = HSIZE;
    hprot_nxt  = HPROT;
    hwdata_nxt = HWDATA;
    ready_nxt  = 1'b0;
    rdata_nxt  = mem_rdata;
    base_nxt   = base;
    wdata_nxt  = wdata_l;
    rest_nxt   = rest;
    case (state)
      S_IDLE: begin
        if (mem_valid) begin
          base_nxt   = mem_addr[31:2];
          wdata_nxt  = mem_wdata;
          rest_nxt   = first.rest;
          htrans_nxt = TR_NONSEQ;
          haddr_nxt  = {mem_addr[31:2], first.off};
          hsize_nxt  = first.size;
          hwrite_nxt = |mem_wstrb;
          hprot_nxt  = {2'b00, HPROT_PRIV, ~mem_instr};
        end
      end
      S_ADDR: begin
        if (HREADY) hwdata_nxt = wdata_l;
        else        htrans_nxt = TR_NONSEQ;
      end
      S_DATA: begin
        if (HREADY) begin
          if (HRESP) begin
            // Dropping the remaining strobes ends the request after this beat.
            rest_nxt  = 4'b0000;
            ready_nxt = 1'b1;
            if (!HWRITE) rdata_nxt = 32'h0;
          end else begin
            if (!HWRITE) rdata_nxt = HRDATA;
            if (rest != 4'b0000) begin
              htrans_nxt = TR_NONSEQ;
              haddr_nxt  = {base, next_lane};
              hsize_nxt  = SZ_BYTE;
              rest_nxt   = rest & ~(4'b0001 << next_lane);
            end else begin
              ready_nxt = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HTRANS    <= TR_IDLE;
      HADDR     <= 32'h0;
      HWRITE    <= 1'b0;
      HSIZE     <= SZ_WORD;
      HPROT     <= {2'b00, HPROT_PRIV, 1'b1};
      HWDATA    <= 32'h0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      base      <= 30'h0;
      wdata_l   <= 32'h0;
      rest      <= 4'b0000;
    end else begin
      HTRANS    <= htrans_nxt;
      HADDR     <= haddr_nxt;
      HWRITE    <= hwrite_nxt;
      HSIZE     <= hsize_nxt;
      HPROT     <= hprot_nxt;
      HWDATA    <= hwdata_nxt;
      mem_ready <= ready_nxt;
      mem_rdata <= rdata_nxt;
      base      <= base_nxt;
      wdata_l   <= wdata_nxt;
      rest      <= rest_nxt;
    end
  end

`ifdef AHB_MST_ERR_IRQ_EN
  logic err_hit;
  assign err_hit = (state == S_DATA) && HREADY && HRESP;

  // A new error in the same cycle as err_clr keeps the flag set; only the first address is kept.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_irq  <= 1'b0;
      err_addr <= 32'h0;
    end else if (err_hit) begin
      err_irq <= 1'b1;
      if (!err_irq) err_addr <= HADDR;
    end else if (err_clr) begin
      err_irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_picorv32_ahb_master.sv
// Directed bench for picorv32_ahb_master: strobe-decode vector table plus wait-state, error and reset sequences.
`timescale 1ns/1ps
module tb_picorv32_ahb_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
`ifdef AHB_MST_ERR_IRQ_EN
  logic        err_irq, err_clr;
  logic [31:0] err_addr;
`endif

  always #5 HCLK = ~HCLK;

  picorv32_ahb_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
`ifdef AHB_MST_ERR_IRQ_EN
    .err_irq(err_irq), .err_addr(err_addr), .err_clr(err_clr),
`endif
    .HRESP(HRESP)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [31:0] rdata;
    int          nbeats;
    logic [31:0] a0, a1, a2;
    logic [2:0]  size;
    int          lat;
  } vec_t;

  localparam int NV = 10;
  vec_t v [NV];

  int tests = 0;
  int fails = 0;
  int nb, lat, pulses, hw_bad, hold_bad, idle_ns;
  logic [31:0] b_addr [4];
  logic [2:0]  b_size [4];
  logic        b_wr   [4];
  logic [3:0]  b_prot [4];
  logic [31:0] got_rdata, last_addr;
  logic [31:0] ea [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One CPU request against a slave model; dwait = data-phase wait states,
  // err_beat = beat number (1-based) answered with a two-cycle ERROR, 0 for none.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic instr, input logic [31:0] rdata, input int dwait, input int err_beat);
    bit in_data, acc;
    int dcnt;
    nb = 0; lat = -1; pulses = 0; hw_bad = 0; hold_bad = 0; got_rdata = 32'hxxxx_xxxx;
    in_data = 0; acc = 0; dcnt = 0; last_addr = 32'h0;
    @(posedge HCLK); #1;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_instr = instr;
    for (int k = 0; k < 40; k++) begin
      @(negedge HCLK);
      if (mem_ready) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          got_rdata = mem_rdata;
        end
      end
      if (acc) begin
        in_data = 1;
        dcnt = 0;
      end
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEAD_DEAD;
      if (in_data) begin
        if (HTRANS != 2'b00 || HADDR != last_addr) hold_bad++;
        if (wstrb != 4'b0000 && HWDATA != wdata) hw_bad++;
        if (nb == err_beat) begin
          HRESP = 1'b1;
          HREADY = (dcnt >= 1);
          HRDATA = rdata;
        end else begin
          HREADY = (dcnt >= dwait);
          if (HREADY) HRDATA = rdata;
        end
        if (HREADY) in_data = 0;
        dcnt++;
      end
      acc = 0;
      if (HTRANS == 2'b10) begin
        if (nb < 4) begin
          b_addr[nb] = HADDR; b_size[nb] = HSIZE; b_wr[nb] = HWRITE; b_prot[nb] = HPROT;
        end
        last_addr = HADDR;
        nb++;
        acc = HREADY;
      end
      if (lat >= 0 && k == lat) begin
        @(posedge HCLK); #1;
        mem_valid = 1'b0;
      end
      if (lat >= 0 && k >= lat + 3) break;
    end
    mem_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{32'h4000_4000, 32'h0,         4'b0000, 1'b0, 32'hA5A5_1234, 1, 32'h4000_4000, 32'h0,         32'h0,         3'b010, 3};
    v[1] = '{32'h2000_0010, 32'hBEEF_BEEF, 4'b1100, 1'b0, 32'h0,         1, 32'h2000_0012, 32'h0,         32'h0,         3'b001, 3};
    v[2] = '{32'h2000_0020, 32'h1122_3344, 4'b1011, 1'b0, 32'h0,         3, 32'h2000_0020, 32'h2000_0021, 32'h2000_0023, 3'b000, 7};
    v[3] = '{32'h0000_1007, 32'h0,         4'b0000, 1'b1, 32'h0000_0013, 1, 32'h0000_1004, 32'h0,         32'h0,         3'b010, 3};
    v[4] = '{32'h3000_0008, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0,         1, 32'h3000_0008, 32'h0,         32'h0,         3'b010, 3};
    v[5] = '{32'h3000_0102, 32'h1234_1234, 4'b0011, 1'b0, 32'h0,         1, 32'h3000_0100, 32'h0,         32'h0,         3'b001, 3};
    v[6] = '{32'h3000_0200, 32'h7777_7777, 4'b0100, 1'b0, 32'h0,         1, 32'h3000_0202, 32'h0,         32'h0,         3'b000, 3};
    v[7] = '{32'h3000_0300, 32'hABAB_ABAB, 4'b0110, 1'b0, 32'h0,         2, 32'h3000_0301, 32'h3000_0302, 32'h0,         3'b000, 5};
    v[8] = '{32'h3000_0400, 32'h5A5A_5A5A, 4'b1000, 1'b0, 32'h0,         1, 32'h3000_0403, 32'h0,         32'h0,         3'b000, 3};
    v[9] = '{32'h3000_0500, 32'h0102_0304, 4'b1001, 1'b0, 32'h0,         2, 32'h3000_0500, 32'h3000_0503, 32'h0,         3'b000, 5};

    HRESETn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    mem_wstrb = 4'b0; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
`ifdef AHB_MST_ERR_IRQ_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("reset_htrans", 32'(HTRANS), 32'h0);
    chk("reset_haddr", HADDR, 32'h0);
    chk("reset_hwrite", 32'(HWRITE), 32'h0);
    chk("reset_hsize", 32'(HSIZE), 32'h2);
    chk("reset_hwdata", HWDATA, 32'h0);
    chk("reset_hburst", 32'(HBURST), 32'h0);
    chk("reset_mem_ready", 32'(mem_ready), 32'h0);
    chk("reset_mem_rdata", mem_rdata, 32'h0);

    for (int i = 0; i < NV; i++) begin
      ea[0] = v[i].a0; ea[1] = v[i].a1; ea[2] = v[i].a2;
      do_req(v[i].addr, v[i].wdata, v[i].wstrb, v[i].instr, v[i].rdata, 0, 0);
      chk($sformatf("v%0d_beats", i), nb, v[i].nbeats);
      for (int j = 0; j < v[i].nbeats && j < 3; j++) begin
        chk($sformatf("v%0d_haddr%0d", i, j), b_addr[j], ea[j]);
        chk($sformatf("v%0d_hsize%0d", i, j), 32'(b_size[j]), 32'(v[i].size));
        chk($sformatf("v%0d_hwrite%0d", i, j), 32'(b_wr[j]), 32'(|v[i].wstrb));
        chk($sformatf("v%0d_hprot%0d", i, j), 32'(b_prot[j]), 32'({2'b00, 1'b1, ~v[i].instr}));
      end
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_ready_pulses", i), pulses, 1);
      chk($sformatf("v%0d_hwdata", i), hw_bad, 0);
      chk($sformatf("v%0d_dphase_hold", i), hold_bad, 0);
      if (v[i].wstrb == 4'b0000) chk($sformatf("v%0d_rdata", i), got_rdata, v[i].rdata);
    end

    // Three data-phase wait states on a read.
    do_req(32'h4000_4000, 32'h0, 4'b0000, 1'b0, 32'h600D_CAFE, 3, 0);
    chk("wait_beats", nb, 1);
    chk("wait_latency", lat, 6);
    chk("wait_hold", hold_bad, 0);
    chk("wait_rdata", got_rdata, 32'h600D_CAFE);
    chk("wait_pulses", pulses, 1);

    // ERROR on the first beat of a split 1011 write.
    do_req(32'h2000_0020, 32'h1122_3344, 4'b1011, 1'b0, 32'h0, 0, 1);
    chk("err_wr_beats", nb, 1);
    chk("err_wr_haddr", b_addr[0], 32'h2000_0020);
    chk("err_wr_latency", lat, 4);
    chk("err_wr_pulses", pulses, 1);
`ifdef AHB_MST_ERR_IRQ_EN
    chk("err_irq_set", 32'(err_irq), 32'h1);
    chk("err_addr_first", err_addr, 32'h2000_0020);
`endif

    // Errored read returns zero even though the slave drives data.
    do_req(32'h4000_4008, 32'h0, 4'b0000, 1'b0, 32'h5A5A_5A5A, 0, 1);
    chk("err_rd_latency", lat, 4);
    chk("err_rd_rdata", got_rdata, 32'h0);
    chk("err_rd_pulses", pulses, 1);
`ifdef AHB_MST_ERR_IRQ_EN
    chk("err_addr_kept", err_addr, 32'h2000_0020);
    @(posedge HCLK); #1 err_clr = 1'b1;
    @(posedge HCLK); #1 err_clr = 1'b0;
    @(negedge HCLK);
    chk("err_irq_cleared", 32'(err_irq), 32'h0);
`endif

    // Reset asserted in the data phase of a read.
    @(posedge HCLK); #1;
    mem_valid = 1'b1; mem_addr = 32'h4000_4444; mem_wdata = 32'h5555_AAAA; mem_wstrb = 4'b0000; mem_instr = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    chk("rst_pre_nonseq", 32'(HTRANS), 32'h2);
    @(negedge HCLK);
    HREADY = 1'b0;
    chk("rst_pre_hwdata", HWDATA, 32'h5555_AAAA);
    #2 HRESETn = 1'b0; mem_valid = 1'b0;
    #1;
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_mem_ready", 32'(mem_ready), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1; HREADY = 1'b1;
    idle_ns = 0;
    repeat (3) begin
      @(negedge HCLK);
      if (HTRANS == 2'b10) idle_ns++;
    end
    chk("rst_no_replay", idle_ns, 0);
    do_req(32'h4000_4000, 32'h0, 4'b0000, 1'b0, 32'h0BAD_F00D, 0, 0);
    chk("post_rst_beats", nb, 1);
    chk("post_rst_haddr", b_addr[0], 32'h4000_4000);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_rdata", got_rdata, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
